spi_reg_bridge: RTL and testbench

- Protocol stage directly downstream of spi_dev_core.
- Consumes the core's received-byte stream and chip-select events, and supplies its transmit byte.
- Decodes a command/address/data framing into a simple 8-bit register bus (write strobe, read strobe, 1-cycle read latency).
- Lets the host SPI master read and write design registers or small memories.

---
 rtl/spi_reg_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// SPI command/address/data framing to an 8-bit register bus with a 1-cycle read latency.
// Optional status readback is enabled with `define SPI_REG_BRIDGE_STATUS_EN.
module spi_reg_bridge #(
    parameter int         AWIDTH = 8,
    parameter logic [7:0] CMD_WR = 8'h01,
    parameter logic [7:0] CMD_RD = 8'h02
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        user_out,
    input  logic              user_out_stb,
    output logic [7:0]        user_in,
    input  logic              user_in_ack,
    input  logic              csn_state,
    input  logic              csn_rise,
    input  logic              csn_fall,
    output logic [AWIDTH-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_WR_ADDR = 3'd2,
        S_RD_ADDR = 3'd3,
        S_WR_DATA = 3'd4,
        S_RD_DATA = 3'd5,
        S_IGNORE  = 3'd6,
        S_STATUS  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [7:0]        bus_wdata_q, bus_wdata_d;
    logic              bus_we_q, bus_we_d;
    logic              bus_re_q, bus_re_d;
    logic              rd_pend_q, rd_pend_d;
    logic [7:0]        user_in_q, user_in_d;
    logic              deselect_s;
    logic [7:0]        fill_s;

    // A falling edge pulse overrides a lagging csn_state in the same cycle
    assign deselect_s = csn_rise | (csn_state & ~csn_fall);

`ifdef SPI_REG_BRIDGE_STATUS_EN
    localparam logic [7:0] CMD_STATUS = 8'h05;

    logic       err_q, err_d;
    logic [6:0] cnt_q, cnt_d;

    assign fill_s = {err_q, cnt_q};

    // Sticky error flag and completed-write counter, cleared only by reset
    always_comb begin
        err_d = err_q;
        cnt_d = cnt_q;
        if ((state_q == S_CMD) && user_out_stb && !deselect_s &&
            (user_out != CMD_WR) && (user_out != CMD_RD) && (user_out != CMD_STATUS)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        if ((state_q == S_WR_DATA) && csn_rise) begin
            cnt_d = cnt_q + 7'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Status register update
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
            cnt_q <= 7'd0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign fill_s = 8'h00;
`endif

    // Next-state and bus/transmit-byte decode
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = 1'b0;
        bus_re_d    = 1'b0;
        rd_pend_d   = bus_re_q;
        user_in_d   = user_in_q;

        // Post-write increment; an address load below takes precedence
        if (bus_we_q) begin
            bus_addr_d = bus_addr_q + AWIDTH'(1);
        end else begin
            bus_addr_d = bus_addr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (csn_fall || !csn_state) begin
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD: begin
                if (user_out_stb) begin
                    case (user_out)
                        CMD_WR:     state_d = S_WR_ADDR;
                        CMD_RD:     state_d = S_RD_ADDR;
`ifdef SPI_REG_BRIDGE_STATUS_EN
                        CMD_STATUS: state_d = S_STATUS;
`endif
                        default:    state_d = S_IGNORE;
                    endcase
                end else begin
                    state_d = S_CMD;
                end
            end
            S_WR_ADDR: begin
                if (user_out_stb) begin
                    bus_addr_d = AWIDTH'(user_out);
                    state_d    = S_WR_DATA;
                end else begin
                    state_d = S_WR_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (user_out_stb) begin
                    bus_addr_d = AWIDTH'(user_out);
                    bus_re_d   = 1'b1;
                    state_d    = S_RD_DATA;
                end else begin
                    state_d = S_RD_ADDR;
                end
            end
            S_WR_DATA: begin
                if (user_out_stb) begin
                    bus_wdata_d = user_out;
                    bus_we_d    = 1'b1;
                end else begin
                    bus_we_d = 1'b0;
                end
            end
            S_RD_DATA: begin
                if (rd_pend_q) begin
                    user_in_d = bus_rdata;
                end else begin
                    user_in_d = user_in_q;
                end
                if (user_in_ack) begin
                    bus_addr_d = bus_addr_q + AWIDTH'(1);
                    bus_re_d   = 1'b1;
                end else begin
                    bus_re_d = 1'b0;
                end
            end
            S_IGNORE: begin
                state_d = S_IGNORE;
            end
`ifdef SPI_REG_BRIDGE_STATUS_EN
            S_STATUS: begin
                if (user_in_ack) begin
                    user_in_d = fill_s;
                end else begin
                    user_in_d = user_in_q;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outside data-return states the transmit byte tracks the fill value
        if ((state_q != S_RD_DATA) && (state_q != S_STATUS)) begin
            user_in_d = fill_s;
        end else begin
            user_in_d = user_in_d;
        end

        // Deselect aborts everything except a write whose byte arrived this cycle
        if (deselect_s) begin
            state_d   = S_IDLE;
            user_in_d = fill_s;
            bus_re_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_addr_q  <= '0;
            bus_wdata_q <= 8'h00;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            user_in_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            bus_re_q    <= bus_re_d;
            rd_pend_q   <= rd_pend_d;
            user_in_q   <= user_in_d;
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_we    = bus_we_q;
    assign bus_re    = bus_re_q;
    assign user_in   = user_in_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected bus strobes are queued at stimulus time
// and matched by a negedge monitor; transmit bytes are checked against a bench memory model.
module tb_spi_reg_bridge;

    logic       clk;
    logic       rst;
    logic [7:0] user_out;
    logic       user_out_stb;
    logic [7:0] user_in;
    logic       user_in_ack;
    logic       csn_state;
    logic       csn_rise;
    logic       csn_fall;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;

    int n_total;
    int n_bad;

    typedef struct packed {
        logic       is_we;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];

    logic [7:0] mem_q [256];
    logic       mem_vld_q [256];

    spi_reg_bridge #(.AWIDTH(8), .CMD_WR(8'h01), .CMD_RD(8'h02)) dut (
        .clk          (clk),
        .rst          (rst),
        .user_out     (user_out),
        .user_out_stb (user_out_stb),
        .user_in      (user_in),
        .user_in_ack  (user_in_ack),
        .csn_state    (csn_state),
        .csn_rise     (csn_rise),
        .csn_fall     (csn_fall),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_we       (bus_we),
        .bus_re       (bus_re),
        .bus_rdata    (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] preload(input logic [7:0] a);
        if (a == 8'h20) return 8'h5A;
        else if (a == 8'h21) return 8'hC3;
        else return a ^ 8'hA5;
    endfunction

    // Register-bus memory model: read data valid one cycle after bus_re
    always @(posedge clk) begin
        if (bus_re) begin
            bus_rdata <= mem_vld_q[bus_addr] ? mem_q[bus_addr] : preload(bus_addr);
        end
        if (bus_we) begin
            mem_q[bus_addr]     <= bus_wdata;
            mem_vld_q[bus_addr] <= 1'b1;
        end
    end

    // Strobe monitor: every strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (bus_we || bus_re) begin
            ev_t e;
            check_val("we_re_excl", {31'd0, bus_we & bus_re}, 32'd0);
            if (exp_q.size() == 0) begin
                check_val(bus_we ? "unexp_we" : "unexp_re", {24'd0, bus_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("strobe_kind", {31'd0, bus_we}, {31'd0, e.is_we});
                check_val("strobe_addr", {24'd0, bus_addr}, {24'd0, e.addr});
                if (e.is_we) check_val("wr_data", {24'd0, bus_wdata}, {24'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_stb(input logic [7:0] b);
        user_out     = b;
        user_out_stb = 1'b1;
        tick();
        user_out_stb = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse_stb(b);
        repeat (4) tick();
    endtask

    task automatic pulse_ack();
        user_in_ack = 1'b1;
        tick();
        user_in_ack = 1'b0;
    endtask

    task automatic cs_start();
        csn_state = 1'b0;
        csn_fall  = 1'b1;
        tick();
        csn_fall = 1'b0;
        tick();
    endtask

    task automatic cs_end();
        csn_rise  = 1'b1;
        csn_state = 1'b1;
        tick();
        csn_rise = 1'b0;
        repeat (3) tick();
    endtask

    task automatic push_we(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back('{is_we: 1'b1, addr: a, data: d});
    endtask

    task automatic push_re(input logic [7:0] a);
        exp_q.push_back('{is_we: 1'b0, addr: a, data: 8'h00});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst          = 1'b1;
        user_out     = 8'h00;
        user_out_stb = 1'b0;
        user_in_ack  = 1'b0;
        csn_state    = 1'b1;
        csn_rise     = 1'b0;
        csn_fall     = 1'b0;
        for (int i = 0; i < 256; i++) mem_vld_q[i] = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_user_in", {24'd0, user_in}, 32'd0);
        check_val("rst_addr", {24'd0, bus_addr}, 32'd0);
        check_val("rst_wdata", {24'd0, bus_wdata}, 32'd0);
        check_val("rst_strobes", {30'd0, bus_we, bus_re}, 32'd0);
        repeat (2) tick();

        // Write burst
        cs_start();
        send_byte(8'h01);
        send_byte(8'h10);
        push_we(8'h10, 8'hAA);
        send_byte(8'hAA);
        push_we(8'h11, 8'hBB);
        send_byte(8'hBB);
        check_val("wr_addr_inc", {24'd0, bus_addr}, 32'h12);
        check_val("wr_user_in", {24'd0, user_in}, 32'd0);
        cs_end();

        // Read burst with one ack
        cs_start();
        send_byte(8'h02);
        push_re(8'h20);
        pulse_stb(8'h20);
        tick();
        check_val("rd0_not_yet", {24'd0, user_in}, 32'd0);
        tick();
        check_val("rd0_data", {24'd0, user_in}, 32'h5A);
        repeat (3) tick();
        check_val("rd0_hold", {24'd0, user_in}, 32'h5A);
        push_re(8'h21);
        pulse_ack();
        check_val("rd1_addr", {24'd0, bus_addr}, 32'h21);
        repeat (2) tick();
        check_val("rd1_data", {24'd0, user_in}, 32'hC3);

        // Reset in the middle of the read burst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_user_in", {24'd0, user_in}, 32'd0);
        check_val("mid_rst_addr", {24'd0, bus_addr}, 32'd0);
        check_val("mid_rst_strobes", {30'd0, bus_we, bus_re}, 32'd0);
        pulse_ack();
        repeat (3) tick();
        check_val("post_rst_ack_ign", {24'd0, user_in}, 32'd0);
        send_byte(8'h02);
        push_re(8'h21);
        send_byte(8'h21);
        check_val("post_rst_rd", {24'd0, user_in}, 32'hC3);
        cs_end();
        check_val("desel_user_in", {24'd0, user_in}, 32'd0);

        // Address wrap
        cs_start();
        send_byte(8'h01);
        send_byte(8'hFF);
        push_we(8'hFF, 8'h11);
        send_byte(8'h11);
        push_we(8'h00, 8'h22);
        send_byte(8'h22);
        check_val("wrap_addr", {24'd0, bus_addr}, 32'h01);
        cs_end();

        // Abort with a data byte coincident with deselect
        cs_start();
        send_byte(8'h01);
        send_byte(8'h30);
        push_we(8'h30, 8'h44);
        send_byte(8'h44);
        push_we(8'h31, 8'h55);
        user_out     = 8'h55;
        user_out_stb = 1'b1;
        csn_rise     = 1'b1;
        csn_state    = 1'b1;
        tick();
        user_out_stb = 1'b0;
        csn_rise     = 1'b0;
        repeat (3) tick();
        cs_start();
        send_byte(8'h02);
        push_re(8'h30);
        send_byte(8'h30);
        check_val("abort_next_rd", {24'd0, user_in}, 32'h44);
        push_re(8'h31);
        pulse_ack();
        repeat (3) tick();
        check_val("abort_next_rd2", {24'd0, user_in}, 32'h55);
        cs_end();

        // Unknown opcode: everything after it is ignored
        cs_start();
        send_byte(8'h7E);
        send_byte(8'h00);
        send_byte(8'h11);
        pulse_ack();
        repeat (3) tick();
`ifdef SPI_REG_BRIDGE_STATUS_EN
        check_val("unk_err_bit", {31'd0, user_in[7]}, 32'd1);
`else
        check_val("unk_user_in", {24'd0, user_in}, 32'd0);
`endif
        cs_end();
        cs_start();
`ifdef SPI_REG_BRIDGE_STATUS_EN
        check_val("status_err_next", {31'd0, user_in[7]}, 32'd1);
`else
        check_val("next_txn_user_in", {24'd0, user_in}, 32'd0);
`endif
        cs_end();

        repeat (5) tick();
        check_val("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
